// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch flushes,
// memory-busy freeze, and saturating stall/flush event counters. State moves on negedge clk.
module pipe_hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16,
    parameter bit IGNORE_R0    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [2:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             ex_mem_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN,
        LOAD_STALL
    } state_t;

    localparam logic [2:0] SCNT_INIT = 3'(STALL_CYCLES - 1);

    state_t     state;
    logic [2:0] scnt;
    logic       hazard;
    logic       stall_now;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign hazard = ex_mem_read
                    && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)))
                    && !(IGNORE_R0 && (ex_rt == 3'd0));

    // While in LOAD_STALL the owed bubbles are issued regardless of the current hazard.
    assign stall_now = (state == LOAD_STALL) || hazard;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!rst_n) begin
            pc_en = 1'b1;
        end else if (mem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (mem_branch_taken) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (stall_now) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // mem_busy freezes everything, so a stall is stretched rather than shortened.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            scnt        <= 3'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (mem_busy) begin
            state <= state;
        end else if (mem_branch_taken) begin
            state       <= RUN;
            scnt        <= 3'd0;
            flush_count <= sat_inc(flush_count);
        end else if (state == LOAD_STALL) begin
            stall_count <= sat_inc(stall_count);
            if (scnt == 3'd1) begin
                state <= RUN;
                scnt  <= 3'd0;
            end else begin
                scnt <= scnt - 3'd1;
            end
        end else if (hazard) begin
            stall_count <= sat_inc(stall_count);
            if (STALL_CYCLES > 1) begin
                state <= LOAD_STALL;
                scnt  <= SCNT_INIT;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: three parameterisations share one stimulus stream
// and are compared each cycle against a bubbles-owed reference model.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [2:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, mem_branch_taken, mem_busy;

    logic [6:0]  ctrl0, ctrl1, ctrl2;
    logic [15:0] sc0, fc0;
    logic [1:0]  sc1, fc1;
    logic [3:0]  sc2, fc2;

    localparam int SC_P [3] = '{1, 3, 7};
    localparam int CW_P [3] = '{16, 2, 4};
    localparam int IR_P [3] = '{1, 1, 0};

    typedef struct packed {
        logic [1:0]  inst;
        logic [6:0]  ctrl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rem [3];
    int   scm [3];
    int   fcm [3];

    pipe_hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(16), .IGNORE_R0(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .mem_busy(mem_busy), .pc_en(ctrl0[6]), .if_id_en(ctrl0[5]), .id_ex_en(ctrl0[4]),
        .ex_mem_en(ctrl0[3]), .id_ex_bubble(ctrl0[2]), .if_id_flush(ctrl0[1]),
        .ex_mem_flush(ctrl0[0]), .stall_count(sc0), .flush_count(fc0));

    pipe_hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(2), .IGNORE_R0(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .mem_busy(mem_busy), .pc_en(ctrl1[6]), .if_id_en(ctrl1[5]), .id_ex_en(ctrl1[4]),
        .ex_mem_en(ctrl1[3]), .id_ex_bubble(ctrl1[2]), .if_id_flush(ctrl1[1]),
        .ex_mem_flush(ctrl1[0]), .stall_count(sc1), .flush_count(fc1));

    pipe_hazard_ctrl #(.STALL_CYCLES(7), .CNT_W(4), .IGNORE_R0(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .mem_busy(mem_busy), .pc_en(ctrl2[6]), .if_id_en(ctrl2[5]), .id_ex_en(ctrl2[4]),
        .ex_mem_en(ctrl2[3]), .id_ex_bubble(ctrl2[2]), .if_id_flush(ctrl2[1]),
        .ex_mem_flush(ctrl2[0]), .stall_count(sc2), .flush_count(fc2));

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Reference: rem = bubbles still owed after the current one; 0 means running freely.
    task automatic model_step();
        exp_t e;
        bit   haz;
        int   maxc;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                rem[i] = 0;
                scm[i] = 0;
                fcm[i] = 0;
            end
            maxc   = (1 << CW_P[i]) - 1;
            e.inst = 2'(i);
            e.sc   = 16'(scm[i]);
            e.fc   = 16'(fcm[i]);
            haz = ex_mem_read && (int'(ex_rt) == int'(id_rs) ||
                                  (id_uses_rt && int'(ex_rt) == int'(id_rt)))
                  && !(IR_P[i] == 1 && int'(ex_rt) == 0);
            if (!rst_n) begin
                e.ctrl = 7'b1111000;
            end else if (mem_busy) begin
                e.ctrl = 7'b0000000;
            end else if (mem_branch_taken) begin
                e.ctrl = 7'b1111111;
                rem[i] = 0;
                if (fcm[i] < maxc) fcm[i]++;
            end else if (rem[i] > 0 || haz) begin
                e.ctrl = 7'b0011100;
                if (scm[i] < maxc) scm[i]++;
                rem[i] = (rem[i] > 0) ? rem[i] - 1 : SC_P[i] - 1;
            end else begin
                e.ctrl = 7'b1111000;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc(input logic r, input logic [2:0] rs, input logic [2:0] rt,
                       input logic uses, input logic mr, input logic [2:0] xr,
                       input logic tk, input logic busy);
        @(posedge clk);
        #1;
        rst_n = r; id_rs = rs; id_rt = rt; id_uses_rt = uses;
        ex_mem_read = mr; ex_rt = xr; mem_branch_taken = tk; mem_busy = busy;
        #1;
        model_step();
    endtask

    function automatic exp_t actual(input logic [1:0] i);
        exp_t a;
        a.inst = i;
        case (i)
            2'd0:    begin a.ctrl = ctrl0; a.sc = sc0;         a.fc = fc0;         end
            2'd1:    begin a.ctrl = ctrl1; a.sc = {14'd0, sc1}; a.fc = {14'd0, fc1}; end
            default: begin a.ctrl = ctrl2; a.sc = {12'd0, sc2}; a.fc = {12'd0, fc2}; end
        endcase
        return a;
    endfunction

    always begin
        exp_t e;
        exp_t a;
        @(posedge clk);
        #5;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual(e.inst);
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL inst%0d t=%0t ctrl act=%b req=%b stall_count act=%0d req=%0d flush_count act=%0d req=%0d",
                         e.inst, $time, a.ctrl, e.ctrl, a.sc, e.sc, a.fc, e.fc);
            end
        end
    end

    initial begin
        rst_n = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt = '0; mem_branch_taken = 1'b0; mem_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin rem[i] = 0; scm[i] = 0; fcm[i] = 0; end

        cyc(0, 3'd3, 3'd0, 0, 1, 3'd3, 1, 0);
        cyc(0, 3'd3, 3'd0, 0, 1, 3'd3, 0, 1);
        // Single load-use hazard, then clear
        cyc(1, 3'd3, 3'd0, 0, 1, 3'd3, 0, 0);
        cyc(1, 3'd3, 3'd0, 0, 0, 3'd3, 0, 0);
        for (int k = 0; k < 8; k++) cyc(1, 3'd1, 3'd2, 0, 0, 3'd5, 0, 0);
        // Hazard with mem_busy in the second bubble
        cyc(1, 3'd3, 3'd0, 0, 1, 3'd3, 0, 0);
        cyc(1, 3'd3, 3'd0, 0, 1, 3'd3, 0, 1);
        cyc(1, 3'd3, 3'd0, 0, 1, 3'd3, 0, 1);
        for (int k = 0; k < 9; k++) cyc(1, 3'd3, 3'd0, 0, 0, 3'd3, 0, 0);
        // Register zero and unused rt
        cyc(1, 3'd0, 3'd0, 0, 1, 3'd0, 0, 0);
        cyc(1, 3'd0, 3'd0, 0, 0, 3'd0, 1, 0);
        cyc(1, 3'd1, 3'd2, 0, 1, 3'd2, 0, 0);
        cyc(1, 3'd1, 3'd2, 1, 1, 3'd2, 0, 0);
        // Taken branch abandons a pending stall
        cyc(1, 3'd4, 3'd0, 0, 1, 3'd4, 0, 0);
        cyc(1, 3'd4, 3'd0, 0, 0, 3'd4, 1, 0);
        cyc(1, 3'd4, 3'd0, 0, 0, 3'd4, 0, 0);
        // Busy masks a taken branch until it drops
        cyc(1, 3'd4, 3'd0, 0, 0, 3'd4, 1, 1);
        cyc(1, 3'd4, 3'd0, 0, 0, 3'd4, 1, 1);
        cyc(1, 3'd4, 3'd0, 0, 0, 3'd4, 1, 0);
        cyc(1, 3'd4, 3'd0, 0, 0, 3'd4, 0, 0);
        // Async reset mid-stall, then clean restart
        cyc(1, 3'd5, 3'd0, 0, 1, 3'd5, 0, 0);
        cyc(1, 3'd5, 3'd0, 0, 1, 3'd5, 0, 0);
        cyc(0, 3'd5, 3'd0, 0, 1, 3'd5, 0, 1);
        cyc(1, 3'd5, 3'd0, 0, 0, 3'd5, 0, 0);
        cyc(1, 3'd5, 3'd0, 0, 1, 3'd5, 0, 0);
        // Counter saturation
        for (int k = 0; k < 20; k++) cyc(1, 3'd1, 3'd0, 0, 0, 3'd2, 1, 0);
        for (int k = 0; k < 40; k++) cyc(1, 3'd2, 3'd0, 0, 1, 3'd2, 0, 0);

        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 99) != 0),
                3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 1'($urandom),
                ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
        end

        @(posedge clk);
        @(posedge clk);
        #8;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
